// File: rtl/raster_pkg.sv
// Shared geometry defaults, coordinate types and channel limits for the raster compositor.
package raster_pkg;

    // Default visible area and blanking geometry
    localparam int DEFAULT_WIDTH     = 16;
    localparam int DEFAULT_HEIGHT    = 12;
    localparam int DEFAULT_H_BLANK   = 2;
    localparam int DEFAULT_V_BLANK   = 1;

    // Default number of rectangle channels and coordinate widths
    localparam int DEFAULT_NUM_BOXES = 2;
    localparam int DEFAULT_X_BITS    = 7;
    localparam int DEFAULT_Y_BITS    = 7;

    // box_id is three bits wide, so at most eight channels can be told apart
    localparam int MAX_BOXES         = 8;
    localparam int BOX_ID_BITS       = 3;

    // Signed coordinates at the default widths
    typedef logic signed [DEFAULT_X_BITS:0] x_coord_t;
    typedef logic signed [DEFAULT_Y_BITS:0] y_coord_t;

    // Index of a rectangle channel
    typedef logic [BOX_ID_BITS-1:0] box_id_t;

endpackage

// File: rtl/raster_timing.sv
// Column/row raster counters with end-of-line, end-of-frame and blanking flags.
module raster_timing
    import raster_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int HEIGHT  = DEFAULT_HEIGHT,
    parameter int H_BLANK = DEFAULT_H_BLANK,
    parameter int V_BLANK = DEFAULT_V_BLANK,
    parameter int X_BITS  = DEFAULT_X_BITS,
    parameter int Y_BITS  = DEFAULT_Y_BITS
)
(
    input  logic            clock,
    input  logic            reset,
    output logic [X_BITS:0] col,
    output logic [Y_BITS:0] row,
    output logic            last_col,
    output logic            last_row,
    output logic            in_hblank,
    output logic            in_vblank
);

    localparam logic [X_BITS:0] COL_MAX = (X_BITS+1)'(WIDTH + H_BLANK - 1);
    localparam logic [Y_BITS:0] ROW_MAX = (Y_BITS+1)'(HEIGHT + V_BLANK - 1);
    localparam logic [X_BITS:0] COL_VIS = (X_BITS+1)'(WIDTH);
    localparam logic [Y_BITS:0] ROW_VIS = (Y_BITS+1)'(HEIGHT);
    localparam logic [X_BITS:0] COL_ONE = (X_BITS+1)'(1);
    localparam logic [Y_BITS:0] ROW_ONE = (Y_BITS+1)'(1);

    assign last_col  = (col == COL_MAX);
    assign last_row  = (row == ROW_MAX);
    assign in_hblank = (col >= COL_VIS);
    assign in_vblank = (row >= ROW_VIS);

    // Advance the column every cycle and step the row each time a line wraps
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (last_col) begin
            col <= '0;
            if (last_row) begin
                row <= '0;
            end else begin
                row <= row + ROW_ONE;
            end
        end else begin
            col <= col + COL_ONE;
        end
    end

endmodule

// File: rtl/raster_compositor.sv
// Overlays up to eight signed rectangles on a raster scan and reports the winning box per pixel.
module raster_compositor
    import raster_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int HEIGHT    = DEFAULT_HEIGHT,
    parameter int H_BLANK   = DEFAULT_H_BLANK,
    parameter int V_BLANK   = DEFAULT_V_BLANK,
    parameter int NUM_BOXES = DEFAULT_NUM_BOXES,
    parameter int X_BITS    = DEFAULT_X_BITS,
    parameter int Y_BITS    = DEFAULT_Y_BITS
)
(
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_BOXES*(Y_BITS+1)-1:0] box_top,
    input  logic [NUM_BOXES*(Y_BITS+1)-1:0] box_bottom,
    input  logic [NUM_BOXES*(X_BITS+1)-1:0] box_left,
    input  logic [NUM_BOXES*(X_BITS+1)-1:0] box_right,
    input  logic [NUM_BOXES-1:0]            box_enable,
    output logic [X_BITS:0]                 pix_x,
    output logic [Y_BITS:0]                 pix_y,
    output logic                            active,
    output logic                            pixel_on,
    output logic [2:0]                      box_id,
    output logic                            hblank,
    output logic                            vblank,
    output logic                            frame_tick
);

    localparam int XW = X_BITS + 1;
    localparam int YW = Y_BITS + 1;

    logic [XW-1:0] col;
    logic [YW-1:0] row;
    logic          last_col;
    logic          last_row;
    logic          in_hblank;
    logic          in_vblank;
    logic          frame_end;
    logic          active_now;

    logic [NUM_BOXES*YW-1:0] top_q;
    logic [NUM_BOXES*YW-1:0] bottom_q;
    logic [NUM_BOXES*XW-1:0] left_q;
    logic [NUM_BOXES*XW-1:0] right_q;
    logic [NUM_BOXES-1:0]    enable_q;

    logic [NUM_BOXES-1:0]    hit;
    logic                    any_hit;
    box_id_t                 win_id;

    raster_timing #(
        .WIDTH   (WIDTH),
        .HEIGHT  (HEIGHT),
        .H_BLANK (H_BLANK),
        .V_BLANK (V_BLANK),
        .X_BITS  (X_BITS),
        .Y_BITS  (Y_BITS)
    ) u_timing (
        .clock     (clock),
        .reset     (reset),
        .col       (col),
        .row       (row),
        .last_col  (last_col),
        .last_row  (last_row),
        .in_hblank (in_hblank),
        .in_vblank (in_vblank)
    );

    assign frame_end  = last_col & last_row;
    assign active_now = ~in_hblank & ~in_vblank;

    // Capture box geometry only at the frame boundary so every frame is drawn from one consistent set
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            top_q    <= '0;
            bottom_q <= '0;
            left_q   <= '0;
            right_q  <= '0;
            enable_q <= '0;
        end else if (frame_end) begin
            top_q    <= box_top;
            bottom_q <= box_bottom;
            left_q   <= box_left;
            right_q  <= box_right;
            enable_q <= box_enable;
        end
    end

    // Per-box hit test: the unsigned counters are widened by one bit so they compare as
    // non-negative signed values, and bound-1 is formed at the wider width so it cannot wrap
    for (genvar k = 0; k < NUM_BOXES; k++) begin : g_box
        logic signed [YW:0] row_s;
        logic signed [YW:0] top_s;
        logic signed [YW:0] bottom_lim;
        logic signed [XW:0] col_s;
        logic signed [XW:0] left_s;
        logic signed [XW:0] right_lim;

        assign row_s      = {1'b0, row};
        assign top_s      = {top_q[k*YW+YW-1], top_q[k*YW +: YW]};
        assign bottom_lim = {bottom_q[k*YW+YW-1], bottom_q[k*YW +: YW]} - (YW+1)'(1);
        assign col_s      = {1'b0, col};
        assign left_s     = {left_q[k*XW+XW-1], left_q[k*XW +: XW]};
        assign right_lim  = {right_q[k*XW+XW-1], right_q[k*XW +: XW]} - (XW+1)'(1);

        assign hit[k] = enable_q[k]
                      & (row_s >= top_s) & (row_s <= bottom_lim)
                      & (col_s >= left_s) & (col_s <= right_lim);
    end

    // Priority select: scanning from the top index down leaves the lowest hitting box as winner
    always_comb begin
        win_id  = '0;
        any_hit = 1'b0;
        for (int k = NUM_BOXES - 1; k >= 0; k--) begin
            if (hit[k]) begin
                win_id  = box_id_t'(k);
                any_hit = 1'b1;
            end
        end
    end

    // Register every output together so the coordinate and its attributes stay aligned
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pix_x      <= '0;
            pix_y      <= '0;
            active     <= 1'b0;
            pixel_on   <= 1'b0;
            box_id     <= '0;
            hblank     <= 1'b0;
            vblank     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            pix_x      <= col;
            pix_y      <= row;
            active     <= active_now;
            pixel_on   <= active_now & any_hit;
            box_id     <= (active_now & any_hit) ? win_id : '0;
            hblank     <= in_hblank;
            vblank     <= in_vblank;
            frame_tick <= frame_end;
        end
    end

endmodule

// File: doc/raster_compositor.md
RASTER_COMPOSITOR -- requirements
Module: raster_compositor

Interface
REQ-001 Parameter WIDTH, default 16: visible columns per line.
REQ-002 Parameter HEIGHT, default 12: visible rows per frame.
REQ-003 Parameter H_BLANK, default 2: blank columns after the visible columns of each line.
REQ-004 Parameter V_BLANK, default 1: blank rows after the visible rows of each frame.
REQ-005 Parameter NUM_BOXES, default 2: number of rectangle channels, range 1..8.
REQ-006 Parameter X_BITS / Y_BITS, default 7 / 7: coordinates are signed [X_BITS:0] / [Y_BITS:0].
REQ-007 clock  in  1  single clock; all flops are on its rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 box_top, box_bottom  in  NUM_BOXES*(Y_BITS+1)  packed signed row bounds; channel k occupies slice k.
REQ-010 box_left, box_right  in  NUM_BOXES*(X_BITS+1)  packed signed column bounds.
REQ-011 box_enable  in  NUM_BOXES  per-channel visibility.
REQ-012 pix_x, pix_y  out  X_BITS+1 / Y_BITS+1  registered coordinate of the current output pixel.
REQ-013 active  out  1  output pixel lies inside the visible area.
REQ-014 pixel_on  out  1  some enabled box covers the output pixel.
REQ-015 box_id  out  3  index of the winning box; 0 when pixel_on=0.
REQ-016 hblank, vblank  out  1  output pixel lies in a blank column / blank row.
REQ-017 frame_tick  out  1  one-cycle pulse marking the end of each frame.

Function
REQ-018 Column counter SHALL count 0..WIDTH+H_BLANK-1 and wrap to 0; on a wrap, the row counter SHALL count 0..HEIGHT+V_BLANK-1 and wrap to 0.
REQ-019 frame_tick SHALL be 1 in the cycle after the counters sit at (WIDTH+H_BLANK-1, HEIGHT+V_BLANK-1), and 0 otherwise.
REQ-020 Shadow registers for all box inputs and box_enable SHALL load only on the last counter cycle of a frame; box_enable is treated like the coordinate inputs, so changes mid-frame have no effect until the next frame.
REQ-021 Box k SHALL hit when top<=row<=bottom-1 and left<=col<=right-1, using signed compares on the shadow values, and only when its shadow enable is set.
REQ-022 A box with bottom<=top or right<=left SHALL never hit; a box with negative or off-screen bounds SHALL be clipped naturally, with no wrap.
REQ-023 Overlap: the lowest-index hitting box wins box_id.
REQ-024 pixel_on SHALL be 0 whenever active=0, regardless of hits.
REQ-025 All outputs SHALL be registered with latency exactly 1 cycle from the counter value they describe: pix_x/pix_y, active, hblank, vblank, pixel_on and box_id stay mutually aligned.
REQ-026 hblank=1 iff col>=WIDTH; vblank=1 iff row>=HEIGHT; active = !hblank & !vblank.
REQ-027 Arithmetic: counters are unsigned and zero-extended into the signed compare; the bound-1 subtraction is done at Y_BITS+2 / X_BITS+2 width so it cannot overflow.

Reset
REQ-028 Reset SHALL clear the counters, all outputs and all shadow registers to 0; the first frame after reset therefore shows no boxes.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately, and counting SHALL restart at (0,0) on the first clock after release.
REQ-030 frame_tick SHALL NOT pulse as a result of reset.

Structure
REQ-031 Package raster_pkg SHALL hold the default geometry constants, the coordinate typedefs and the MAX_BOXES=8 limit.
REQ-032 Sub-module raster_timing SHALL hold the column/row counters and produce the last-column, last-row and blanking flags.
REQ-033 Per-box hit logic SHALL be a generate loop inside raster_compositor, not a separate module.

Verification
Bench parameters: WIDTH=8, HEIGHT=4, H_BLANK=2, V_BLANK=1, NUM_BOXES=2, unless noted.
REQ-034 Free-run after reset -> frame_tick period 50 cycles; first pulse 50 cycles after reset release; hblank high for 2 of every 10 cycles; vblank high for 10 of every 50 cycles.
REQ-035 Box0 = (top 1, bottom 3, left 2, right 5), enabled -> from the second frame on, pixel_on=1 exactly at rows 1-2, cols 2-4 (6 pixels per frame), with box_id=0.
REQ-036 Box0 as above, box1 = (0,4,4,8) -> pixel (col 4, row 1) has box_id=0; pixel (col 5, row 1) has box_id=1; pixel (col 8, row 1) is in blanking, so pixel_on=0.
REQ-037 Move box0 left bound from 2 to 0 at row 2 mid-frame -> the current frame is unchanged; the next frame shows cols 0-4.
REQ-038 Box with top=-2, bottom=1, left=-3, right=1 -> only pixel (col 0, row 0) is lit; degenerate box (top 2, bottom 2) -> never lit.
REQ-039 Assert reset at (col 5, row 2) for 3 cycles -> all outputs are 0 during reset; after release pix_x=0, pix_y=0 one cycle later; no frame_tick pulse is caused by the reset.
